// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: instruction-memory request/response, redirect, and decoder-side stream.
// The master modport is the fetch queue; the slave modport is its environment.
interface ifetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [31:0]   imem_req_addr;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic [31:0]   inst_pc;
    logic [CW-1:0] queue_count;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, queue_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, queue_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
        output inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response queue, redirect
// flush with drain of stale responses. Define IFQ_BYPASS_EN for an empty-queue response bypass.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic [31:0]   redirect_pc_al;
    logic [CW:0]   inflight;
    logic          in_run, credit, req_fire, rsp_take, bypass, push, pop;

    assign redirect_pc_al = {bus.redirect_pc[31:2], 2'b00};
    assign in_run         = (state_q == ST_RUN);
    // Every outstanding request owns a slot, so a response can always be written.
    assign inflight       = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit         = (inflight < DEPTH_W);

    assign bus.imem_req_valid = reset && in_run && !bus.redirect_valid && credit;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.queue_count    = count_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_take = reset && in_run && bus.imem_rsp_valid && !bus.redirect_valid;

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_take && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign pop  = (count_q != '0) && bus.inst_ready && !bus.redirect_valid;
    assign push = rsp_take && !(bypass && bus.inst_ready);

    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst_data  = '0;
        bus.inst_pc    = '0;
        if (count_q != '0) begin
            bus.inst_valid = 1'b1;
            bus.inst_data  = data_mem_q[head_q];
            bus.inst_pc    = pc_mem_q[head_q];
        end else if (bypass) begin
            bus.inst_valid = 1'b1;
            bus.inst_data  = bus.imem_rsp_data;
            bus.inst_pc    = rsp_pc_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;

        if (req_fire && !bus.imem_rsp_valid) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!req_fire && bus.imem_rsp_valid) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        // Responses return in order, so the tag is simply the next expected address.
        if (rsp_take) rsp_pc_d = rsp_pc_q + 32'd4;
        if (push)     tail_d   = tail_q + 1'b1;
        if (pop)      head_d   = head_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (state_q == ST_DRAIN) begin
            if (bus.imem_rsp_valid) drop_d = drop_q - 1'b1;
            if (drop_d == '0) state_d = ST_RUN;
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            if (in_run) begin
                drop_d  = outstanding_d;
                state_d = (outstanding_d != '0) ? ST_DRAIN : ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
        end
    end

    // Storage needs no reset: outputs are gated by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[tail_q] <= bus.imem_rsp_data;
            pc_mem_q[tail_q]   <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue: an in-order memory model with random latency and an
// epoch-tagged reference of the expected instruction stream.
module tb_ifetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ifetch_queue_if #(.DEPTH(DEPTH)) bus ();

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t        mq[$];
    mreq_t       mem[$];
    int          epoch = 0, cyc = 0, last_due = 0;
    logic [31:0] exp_fetch, exp_cons, first_after;
    bit          saw_first = 1'b1, redir_done = 1'b0;
    int          n_vec = 0, n_err = 0, dut_acc = 0, dut_cons = 0;
    int          p_rdy, p_irdy, lat_min, lat_max, p_redir, mode;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h0019_660D) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset                = 1'b0;
        bus.imem_req_ready   = 1'b0;
        bus.inst_ready       = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = '0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        #1;
        check("reset_req_valid", bus.imem_req_valid, 0);
        check("reset_inst_valid", bus.inst_valid, 0);
        check("reset_inst_data", bus.inst_data, 0);
        check("reset_inst_pc", bus.inst_pc, 0);
        check("reset_count", bus.queue_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mq.delete();
        mem.delete();
        epoch++;
        exp_fetch = RESET_PC;
        exp_cons  = RESET_PC;
        last_due  = cyc;
        dut_acc   = 0;
        dut_cons  = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic step();
        mreq_t       r;
        logic [31:0] tgt;
        bit          rsp, rsp_cur, redir, bypass, exp_iv, exp_rv;
        int          old_out, due;

        old_out = 0;
        foreach (mem[i]) if (mem[i].epoch != epoch) old_out++;
        rsp = (mem.size() > 0) && (mem[0].due <= cyc);
        bus.imem_req_ready = ($urandom_range(99) < p_rdy);
        bus.inst_ready     = ($urandom_range(99) < p_irdy);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? data_of(mem[0].addr) : $urandom;

        case (mode)
            1:       redir = !redir_done && old_out == 0 && mem.size() == 2;
            2:       redir = !redir_done && rsp && mem[0].epoch == epoch && mq.size() > 0;
            default: redir = ($urandom_range(999) < p_redir);
        endcase
        if (mode != 0) begin
            tgt = 32'h0000_0100;
        end else begin
            case ($urandom_range(3))
                0:       tgt = 32'h0000_0100;
                1:       tgt = 32'hFFFF_FFFC;
                2:       tgt = 32'hFFFF_FFF8;
                default: tgt = $urandom;
            endcase
            tgt[1:0] = 2'($urandom_range(3));
        end
        if (redir && mode == 2) bus.inst_ready = 1'b1;
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir ? tgt : $urandom;
        #1;

        rsp_cur = rsp && (mem[0].epoch == epoch) && !redir;
`ifdef IFQ_BYPASS_EN
        bypass = rsp_cur && (mq.size() == 0);
`else
        bypass = 1'b0;
`endif
        exp_iv = (mq.size() > 0) || bypass;
        exp_rv = !redir && old_out == 0 && (mem.size() + mq.size() < DEPTH);

        check("queue_count", bus.queue_count, mq.size());
        check("inst_valid", bus.inst_valid, exp_iv);
        if (mq.size() > 0) begin
            check("inst_pc", bus.inst_pc, mq[0].pc);
            check("inst_data", bus.inst_data, mq[0].data);
        end else if (bypass) begin
            check("bypass_pc", bus.inst_pc, mem[0].addr);
            check("bypass_data", bus.inst_data, data_of(mem[0].addr));
        end
        check("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", bus.imem_req_addr, exp_fetch);

        if (bus.imem_req_valid && bus.imem_req_ready) dut_acc++;
        if (bus.inst_valid && bus.inst_ready && !redir) dut_cons++;

        if (rsp) r = mem.pop_front();
        if (redir) begin
            mq.delete();
            epoch++;
            exp_fetch = {tgt[31:2], 2'b00};
            exp_cons  = exp_fetch;
            redir_done = 1'b1;
            saw_first  = 1'b0;
        end else begin
            if (exp_iv && bus.inst_ready) begin
                check("inst_seq", bus.inst_pc, exp_cons);
                exp_cons += 32'd4;
                if (!saw_first) begin
                    first_after = bus.inst_pc;
                    saw_first   = 1'b1;
                end
                if (mq.size() > 0) mq.delete(0);
            end
            if (rsp_cur && !(bypass && bus.inst_ready))
                mq.push_back('{pc: r.addr, data: data_of(r.addr)});
        end
        if (exp_rv && bus.imem_req_ready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem.push_back('{addr: exp_fetch, epoch: epoch, due: due});
            exp_fetch += 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        mode = 0; p_redir = 0; lat_min = 1; lat_max = 1; p_rdy = 100; p_irdy = 100;
        @(negedge clk);

        // Streaming with 1-cycle memory: one instruction per cycle once filled.
        do_reset();
        repeat (20) step();
        check("stream_rate", dut_cons, 18);

        // Decoder stalled: credit limit stops fetch at DEPTH; reset lands mid-flight.
        do_reset();
        p_irdy = 0; lat_max = 2;
        repeat (12) step();
        #1;
        check("fill_requests", dut_acc, DEPTH);
        check("fill_count", bus.queue_count, DEPTH);
        check("fill_req_valid", bus.imem_req_valid, 0);
        p_irdy = 100;
        repeat (15) step();

        // Redirect with exactly two requests in flight.
        do_reset();
        lat_min = 3; lat_max = 3; mode = 1;
        redir_done = 1'b0; saw_first = 1'b1; first_after = 'x;
        repeat (15) step();
        check("drain_resume_pc", first_after, 32'h0000_0100);

        // Redirect coinciding with a live response and a pop.
        lat_min = 1; lat_max = 2; mode = 2;
        redir_done = 1'b0; saw_first = 1'b1; first_after = 'x;
        repeat (20) step();
        check("redir_rsp_pop_pc", first_after, 32'h0000_0100);

        mode = 0;
        for (int k = 0; k < 15; k++) begin
            p_rdy   = $urandom_range(100, 30);
            p_irdy  = $urandom_range(100, 20);
            lat_min = 1;
            lat_max = $urandom_range(4, 1);
            p_redir = $urandom_range(40, 0);
            if (k == 7) do_reset();
            repeat (200) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of 2, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  instruction memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  instruction return valid; responses in order, at least 1 cycle after acceptance, at most one per cycle.
REQ-009 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect pulse.
REQ-011 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 SHALL have port inst_valid  output  1  instruction available to decoder.
REQ-013 SHALL have port inst_ready  input  1  decoder consumes instruction.
REQ-014 SHALL have port inst_data  output  32  instruction word.
REQ-015 SHALL have port inst_pc  output  32  address of inst_data.
REQ-016 SHALL have port queue_count  output  log2(DEPTH)+1  current number of valid entries.

Function
REQ-017 SHALL hold fetch_pc; a request is accepted when imem_req_valid and imem_req_ready are both 1, and fetch_pc then advances by 4, wrapping from 32'hFFFF_FFFC to 0.
REQ-018 SHALL assert imem_req_valid only in state RUN, with redirect_valid = 0 and outstanding + queue_count < DEPTH (credit rule), so the queue never overflows.
REQ-019 SHALL track outstanding requests (accepted, response not yet returned); simultaneous accept and response leave the count unchanged.
REQ-020 SHALL, in RUN, write each response into the queue tail tagged with its request address.
REQ-021 SHALL present the head entry on inst_data/inst_pc with inst_valid = 1 when queue_count > 0; the entry pops when inst_valid and inst_ready are both 1.
REQ-022 SHALL support push and pop in the same cycle with queue_count unchanged, including when full.
REQ-023 SHALL hold inst_data/inst_pc stable while inst_valid = 1 and inst_ready = 0.
REQ-024 SHALL implement states RUN and DRAIN.
REQ-025 SHALL, on redirect_valid = 1, flush the queue (queue_count = 0 next cycle), set fetch_pc = redirect_pc, and ignore inst_ready that cycle.
REQ-026 SHALL, on redirect, go to DRAIN with drop_count = outstanding (excluding any response in the same cycle, which is itself discarded) if that value is nonzero; otherwise stay or return to RUN.
REQ-027 SHALL, in DRAIN, discard every response, decrement drop_count, issue no requests, and return to RUN the cycle after drop_count reaches 0.
REQ-028 SHALL, on redirect during DRAIN, update fetch_pc, keep the current drop_count and stay in DRAIN.
REQ-029 SHALL, without IFQ_BYPASS_EN, make a response visible on inst_valid no earlier than 1 cycle after imem_rsp_valid.

Reset
REQ-030 SHALL, while reset = 0, force fetch_pc = RESET_PC, state RUN, queue_count = 0, outstanding = 0, drop_count = 0, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-031 SHALL discard responses to requests issued before a mid-operation reset; the environment resets the memory together with this block.
REQ-032 SHALL issue the first request at RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, with IFQ_BYPASS_EN defined, drive an in-RUN response straight to inst_valid/inst_data/inst_pc in the same cycle when the queue is empty; if inst_ready = 1 it is consumed without being written, otherwise it is enqueued.
REQ-034 SHALL, with IFQ_BYPASS_EN undefined, always route responses through queue storage with registered outputs.

Verification
REQ-035 Reset release, imem_req_ready = 1, 1-cycle memory latency, inst_ready = 1 -> inst_pc sequence 0x0, 0x4, 0x8 with matching words, one per cycle after fill.
REQ-036 inst_ready = 0 with DEPTH = 4 -> exactly 4 requests issued, queue_count = 4, imem_req_valid = 0, no lost or duplicated words after inst_ready = 1.
REQ-037 Redirect to 0x100 with 2 requests outstanding -> state DRAIN, 2 responses dropped, next inst_pc = 0x100.
REQ-038 Redirect in the same cycle as a response and a pop -> queue empty next cycle, response discarded, fetch resumes at redirect_pc.
REQ-039 fetch_pc = 0xFFFF_FFFC accepted -> next imem_req_addr = 0x0.
REQ-040 IFQ_BYPASS_EN defined, empty queue, response 0x0000_0013 with inst_ready = 1 -> inst_valid = 1 and inst_data = 0x0000_0013 in the same cycle, queue_count stays 0.
